// File: rtl/sobel_window_gen_pkg.sv
// Shared constants and types for the Sobel 3x3 window generator.
package sobel_window_gen_pkg;

  // Grayscale pixel width seen on the window outputs
  localparam int PIXEL_WIDTH_OUT = 8;

  // Default image geometry
  localparam int IMG_WIDTH_DEFAULT  = 8;
  localparam int IMG_HEIGHT_DEFAULT = 8;

  // Frame tracking states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_FILL   = 2'd1;
  localparam state_t ST_STREAM = 2'd2;

endpackage

// File: rtl/sobel_window_gen_line_buffer.sv
// Line buffer: delays the pixel stream by exactly DEPTH enabled shifts.
// Storage is a register chain so the whole buffer clears on reset.
module sobel_line_buffer
  import sobel_window_gen_pkg::*;
#(
  parameter int DEPTH = IMG_WIDTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       shift_en,
  input  logic [PIXEL_WIDTH_OUT-1:0] pixel,
  output logic [PIXEL_WIDTH_OUT-1:0] delayed_pixel
);

  logic [PIXEL_WIDTH_OUT-1:0] tap [DEPTH+1];

  assign tap[0] = pixel;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [PIXEL_WIDTH_OUT-1:0] stage_reg;

      // One delay stage, advancing only on accepted pixels
      always_ff @(posedge clk) begin
        if (!nreset) begin
          stage_reg <= '0;
        end else if (shift_en) begin
          stage_reg <= tap[gi];
        end
      end

      assign tap[gi+1] = stage_reg;
    end
  endgenerate

  assign delayed_pixel = tap[DEPTH];

endmodule

// File: rtl/sobel_window_gen.sv
// Builds a 3x3 raster window for a Sobel core and flags windows that lie
// entirely inside the image. Outputs o0..o8 map straight onto core i0..i8.
module sobel_window_gen
  import sobel_window_gen_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEFAULT,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       nreset_i,
  input  logic [PIXEL_WIDTH_OUT-1:0] pixel_i,
  input  logic                       valid_i,
  input  logic                       sof_i,
  output logic [PIXEL_WIDTH_OUT-1:0] matrix_pixels_o0,
  output logic [PIXEL_WIDTH_OUT-1:0] matrix_pixels_o1,
  output logic [PIXEL_WIDTH_OUT-1:0] matrix_pixels_o2,
  output logic [PIXEL_WIDTH_OUT-1:0] matrix_pixels_o3,
  output logic [PIXEL_WIDTH_OUT-1:0] matrix_pixels_o4,
  output logic [PIXEL_WIDTH_OUT-1:0] matrix_pixels_o5,
  output logic [PIXEL_WIDTH_OUT-1:0] matrix_pixels_o6,
  output logic [PIXEL_WIDTH_OUT-1:0] matrix_pixels_o7,
  output logic [PIXEL_WIDTH_OUT-1:0] matrix_pixels_o8,
  output logic                       window_valid_o,
  output logic                       frame_done_o
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  state_t           state_reg, state_next;
  logic [COL_W-1:0] col_reg, col_next, pos_col;
  logic [ROW_W-1:0] row_reg, row_next, pos_row;
  logic             window_valid_reg, window_valid_next;
  logic             frame_done_reg, frame_done_next;
  logic             accept;
  logic             last_col;

  logic [PIXEL_WIDTH_OUT-1:0] buf_a_out, buf_b_out;
  logic [PIXEL_WIDTH_OUT-1:0] col_in [3];
  logic [PIXEL_WIDTH_OUT-1:0] window [9];

  // Frame tracking: sof always restarts at (0,0), even mid-frame
  always_comb begin
    accept            = valid_i && (sof_i || (state_reg != ST_IDLE));
    pos_col           = sof_i ? '0 : col_reg;
    pos_row           = sof_i ? '0 : row_reg;
    last_col          = (pos_col == COL_W'(IMG_WIDTH - 1));
    state_next        = state_reg;
    col_next          = col_reg;
    row_next          = row_reg;
    window_valid_next = 1'b0;
    frame_done_next   = 1'b0;
    if (accept) begin
      window_valid_next = (pos_row >= ROW_W'(2)) && (pos_col >= COL_W'(2));
      col_next          = last_col ? '0 : pos_col + COL_W'(1);
      row_next          = last_col ? pos_row + ROW_W'(1) : pos_row;
      if (sof_i) begin
        state_next = ST_FILL;
      end else if (state_reg == ST_FILL && pos_row == ROW_W'(1) && last_col) begin
        state_next = ST_STREAM;
      end else if (state_reg == ST_STREAM && pos_row == ROW_W'(IMG_HEIGHT - 1) && last_col) begin
        state_next      = ST_IDLE;
        row_next        = '0;
        frame_done_next = 1'b1;
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state_reg        <= ST_IDLE;
      col_reg          <= '0;
      row_reg          <= '0;
      window_valid_reg <= 1'b0;
      frame_done_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      col_reg          <= col_next;
      row_reg          <= row_next;
      window_valid_reg <= window_valid_next;
      frame_done_reg   <= frame_done_next;
    end
  end

  // Buffer A holds the previous line, buffer B the line before that
  sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_buf_a (
    .clk           (clk_i),
    .nreset        (nreset_i),
    .shift_en      (accept),
    .pixel         (pixel_i),
    .delayed_pixel (buf_a_out)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_buf_b (
    .clk           (clk_i),
    .nreset        (nreset_i),
    .shift_en      (accept),
    .pixel         (buf_a_out),
    .delayed_pixel (buf_b_out)
  );

  assign col_in[0] = buf_b_out;
  assign col_in[1] = buf_a_out;
  assign col_in[2] = pixel_i;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      logic [PIXEL_WIDTH_OUT-1:0] tap_reg [3];

      // Window row: shift left, newest column enters on the right
      always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
          tap_reg <= '{default: '0};
        end else if (accept) begin
          tap_reg[0] <= tap_reg[1];
          tap_reg[1] <= tap_reg[2];
          tap_reg[2] <= col_in[gi];
        end
      end

      assign window[gi*3+0] = tap_reg[0];
      assign window[gi*3+1] = tap_reg[1];
      assign window[gi*3+2] = tap_reg[2];
    end
  endgenerate

  assign matrix_pixels_o0 = window[0];
  assign matrix_pixels_o1 = window[1];
  assign matrix_pixels_o2 = window[2];
  assign matrix_pixels_o3 = window[3];
  assign matrix_pixels_o4 = window[4];
  assign matrix_pixels_o5 = window[5];
  assign matrix_pixels_o6 = window[6];
  assign matrix_pixels_o7 = window[7];
  assign matrix_pixels_o8 = window[8];
  assign window_valid_o   = window_valid_reg;
  assign frame_done_o     = frame_done_reg;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on a 4x4 image.
module tb_sobel_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk_i = 1'b0;
  logic       nreset_i = 1'b0;
  logic [7:0] pixel_i = '0;
  logic       valid_i = 1'b0;
  logic       sof_i = 1'b0;
  logic [7:0] o0, o1, o2, o3, o4, o5, o6, o7, o8;
  logic       window_valid_o, frame_done_o;
  logic [7:0] dut_win [9];

  always #5 clk_i = ~clk_i;

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk_i            (clk_i),
    .nreset_i         (nreset_i),
    .pixel_i          (pixel_i),
    .valid_i          (valid_i),
    .sof_i            (sof_i),
    .matrix_pixels_o0 (o0),
    .matrix_pixels_o1 (o1),
    .matrix_pixels_o2 (o2),
    .matrix_pixels_o3 (o3),
    .matrix_pixels_o4 (o4),
    .matrix_pixels_o5 (o5),
    .matrix_pixels_o6 (o6),
    .matrix_pixels_o7 (o7),
    .matrix_pixels_o8 (o8),
    .window_valid_o   (window_valid_o),
    .frame_done_o     (frame_done_o)
  );

  assign dut_win[0] = o0;
  assign dut_win[1] = o1;
  assign dut_win[2] = o2;
  assign dut_win[3] = o3;
  assign dut_win[4] = o4;
  assign dut_win[5] = o5;
  assign dut_win[6] = o6;
  assign dut_win[7] = o7;
  assign dut_win[8] = o8;

  int vectors = 0;
  int miscompares = 0;
  int step_no = 0;
  int strobes = 0;
  int dones = 0;

  // Reference model: frame position, current frame image, and the full
  // history of accepted pixels since reset (window = delayed history taps).
  bit         m_active = 1'b0;
  int         m_k = 0;
  logic [7:0] img [H][W];
  logic [7:0] hist [$];

  typedef struct {
    logic       v;
    logic       s;
    logic [7:0] p;
    logic       exp_wv;
    logic       exp_fd;
    logic [7:0] exp_o0;
    logic [7:0] exp_o8;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step_no, act, exp);
    end
  endtask

  function automatic logic [7:0] hist_at(input int delay);
    int idx;
    idx = hist.size() - 1 - delay;
    return (idx < 0) ? 8'h00 : hist[idx];
  endfunction

  // Apply one cycle of stimulus, advance the model, compare after the edge
  task automatic step(input logic v, input logic s, input logic [7:0] p, input logic n);
    bit acc, exp_wv, exp_fd;
    int r, c;
    valid_i  = v;
    sof_i    = s;
    pixel_i  = p;
    nreset_i = n;
    exp_wv = 1'b0;
    exp_fd = 1'b0;
    r = 0;
    c = 0;
    if (!n) begin
      m_active = 1'b0;
      m_k = 0;
      hist.delete();
    end else begin
      acc = v && (s || m_active);
      if (acc) begin
        if (s) begin
          m_active = 1'b1;
          m_k = 0;
        end
        r = m_k / W;
        c = m_k % W;
        img[r][c] = p;
        hist.push_back(p);
        exp_wv = (r >= 2) && (c >= 2);
        m_k++;
        if (m_k == W * H) begin
          m_active = 1'b0;
          m_k = 0;
          exp_fd = 1'b1;
        end
      end
    end
    @(posedge clk_i);
    #1;
    step_no++;
    $display("step %0d v=%0b s=%0b px=%02h n=%0b -> wv=%0b fd=%0b o0=%02h o4=%02h o8=%02h",
             step_no, v, s, p, n, window_valid_o, frame_done_o, o0, o4, o8);
    chk("window_valid", window_valid_o, exp_wv);
    chk("frame_done", frame_done_o, exp_fd);
    if (window_valid_o) strobes++;
    if (frame_done_o) dones++;
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("win_o%0d", j * 3 + k), dut_win[j*3+k], hist_at((2 - j) * W + (2 - k)));
        if (exp_wv)
          chk($sformatf("nbr_o%0d", j * 3 + k), dut_win[j*3+k], img[r-2+j][c-2+k]);
      end
    end
  endtask

  // Send the standard pattern frame (pixel = row*16+col), optionally gapped
  task automatic send_pixels(input int count, input bit toggle);
    for (int k = 0; k < count; k++) begin
      step(1'b1, k == 0, 8'((k / W) * 16 + (k % W)), 1'b1);
      if (toggle) step(1'b0, 1'b0, 8'($urandom), 1'b1);
    end
  endtask

  logic [7:0] first_win [9];

  initial begin
    first_win = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
    for (int k = 0; k < W * H; k++) begin
      tbl[k].v      = 1'b1;
      tbl[k].s      = (k == 0);
      tbl[k].p      = 8'((k / W) * 16 + (k % W));
      tbl[k].exp_wv = ((k / W) >= 2) && ((k % W) >= 2);
      tbl[k].exp_fd = (k == W * H - 1);
      tbl[k].exp_o0 = 8'(((k / W) - 2) * 16 + (k % W) - 2);
      tbl[k].exp_o8 = tbl[k].p;
    end
    tbl[16] = '{v: 1'b0, s: 1'b0, p: 8'h5a, exp_wv: 1'b0, exp_fd: 1'b0, exp_o0: 8'h00, exp_o8: 8'h00};

    // Reset state
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'hff, 1'b0);
    for (int i = 0; i < 9; i++) chk("reset_win", dut_win[i], 8'h00);

    // Table-driven full frame with continuous valid
    strobes = 0;
    dones = 0;
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].p, 1'b1);
      chk("tbl_wv", window_valid_o, tbl[i].exp_wv);
      chk("tbl_fd", frame_done_o, tbl[i].exp_fd);
      if (tbl[i].exp_wv) begin
        chk("tbl_o0", o0, tbl[i].exp_o0);
        chk("tbl_o8", o8, tbl[i].exp_o8);
      end
      if (i == 10)
        for (int j = 0; j < 9; j++) chk("first_window", dut_win[j], first_win[j]);
    end
    chk("frame_strobes", strobes, 4);
    chk("frame_dones", dones, 1);

    // Gapped valid: same windows, frozen outputs between pixels
    strobes = 0;
    send_pixels(W * H, 1'b1);
    chk("gapped_strobes", strobes, 4);

    // Junk in IDLE, then a frame
    strobes = 0;
    dones = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom), 1'b1);
    chk("junk_strobes", strobes, 0);
    send_pixels(W * H, 1'b0);
    chk("junk_frame_strobes", strobes, 4);
    chk("junk_frame_dones", dones, 1);

    // Abort: sof reasserted at pixel (2,1)
    strobes = 0;
    dones = 0;
    send_pixels(2 * W + 1, 1'b0);
    send_pixels(W * H, 1'b0);
    chk("abort_strobes", strobes, 4);
    chk("abort_dones", dones, 1);

    // Reset during row 2, then a dropped pixel, then a clean frame
    strobes = 0;
    dones = 0;
    send_pixels(2 * W + 2, 1'b0);
    step(1'b1, 1'b0, 8'h77, 1'b0);
    for (int i = 0; i < 9; i++) chk("midreset_win", dut_win[i], 8'h00);
    step(1'b1, 1'b0, 8'h66, 1'b1);
    send_pixels(W * H, 1'b0);
    chk("midreset_strobes", strobes, 4);
    chk("midreset_dones", dones, 1);

    // Back-to-back frames
    strobes = 0;
    dones = 0;
    send_pixels(W * H, 1'b0);
    send_pixels(W * H, 1'b0);
    chk("b2b_strobes", strobes, 8);
    chk("b2b_dones", dones, 2);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic v, s, n;
      v = ($urandom_range(0, 3) != 0);
      s = m_active ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
      n = ($urandom_range(0, 299) != 0);
      step(v, s, 8'($urandom), n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 Parameter IMG_WIDTH, default 8: pixels per image line, >=3.
REQ-002 Parameter IMG_HEIGHT, default 8: lines per frame, >=3.
REQ-003 clk_i  input  1  sole clock; all state changes on the rising edge.
REQ-004 nreset_i  input  1  reset, synchronous and active-low.
REQ-005 pixel_i  input  PIXEL_WIDTH_OUT  raster-order grayscale pixel.
REQ-006 valid_i  input  1  pixel_i is accepted this cycle; no backpressure.
REQ-007 sof_i  input  1  start of frame, qualified by valid_i; marks pixel (row 0, col 0).
REQ-008 matrix_pixels_o0..o8  output  PIXEL_WIDTH_OUT each  3x3 window, row-major, o0 = top-left, o8 = bottom-right.
REQ-009 window_valid_o  output  1  one-cycle strobe: o0..o8 hold a complete in-image window.
REQ-010 frame_done_o  output  1  one-cycle strobe after the last pixel of a frame is accepted.

Function
REQ-011 States: IDLE, FILL, STREAM; reset state IDLE.
REQ-012 IDLE: drops pixels with valid_i=1, sof_i=0; valid_i=1 with sof_i=1 -> FILL, pixel taken as (0,0).
REQ-013 FILL -> STREAM on the accepted pixel that completes row 1 (row 1, col IMG_WIDTH-1).
REQ-014 STREAM -> IDLE on the accepted pixel (IMG_HEIGHT-1, IMG_WIDTH-1); frame_done_o=1 the next cycle.
REQ-015 Column counter 0..IMG_WIDTH-1 advances per accepted pixel and wraps to 0; row counter increments on wrap.
REQ-016 valid_i=0: no counter, line-buffer or window change; window_valid_o=0.
REQ-017 Two line buffers, each delaying by exactly IMG_WIDTH accepted pixels; buffer A fed by pixel_i, buffer B fed by buffer A output.
REQ-018 Accepted pixel shifts each window row left by one (col0<=col1, col1<=col2); new col2 = buffer B output (top row), buffer A output (middle row), pixel_i (bottom row).
REQ-019 window_valid_o=1 the cycle after an accepted pixel with row>=2 and col>=2; latency exactly 1 cycle.
REQ-020 Windows spanning a line wrap never flagged valid; exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) strobes per frame.
REQ-021 sof_i=1 with valid_i=1 in FILL or STREAM aborts the frame: pixel taken as (0,0), state FILL, no frame_done_o; stale buffer data stays masked by REQ-019.
REQ-022 sof_i ignored when valid_i=0.
REQ-023 o0..o8 hold value between accepted pixels; changes only on accepted pixels.

Reset
REQ-024 nreset_i=0 at a clock edge: state IDLE, counters 0, window registers 0, line-buffer storage 0.
REQ-025 Reset outputs: o0..o8=0, window_valid_o=0, frame_done_o=0.
REQ-026 Reset mid-frame discards the frame; next pixel dropped unless it carries sof_i.

Structure
REQ-027 PIXEL_WIDTH_OUT plus the new IMG_WIDTH/IMG_HEIGHT defaults and the state enum type live in the shared parameters.svh.
REQ-028 Line buffer is one sub-module, sobel_line_buffer (parameter DEPTH, data width PIXEL_WIDTH_OUT, shift enable, sync active-low reset), instantiated twice.
REQ-029 Outputs o0..o8 connect port-for-port to the Sobel core matrix inputs i0..i8.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pixel = row*16+col)
REQ-030 Full frame, valid_i=1 continuously -> first strobe after pixel (2,2): o0..o8 = 00,01,02,10,11,12,20,21,22 (hex); 4 strobes total; frame_done_o one cycle after pixel (3,3).
REQ-031 Same frame, valid_i toggling 1/0 -> identical window sequence; outputs frozen during valid_i=0 cycles.
REQ-032 Pixels without sof_i in IDLE, then sof_i frame -> leading pixels ignored; windows as REQ-030.
REQ-033 sof_i reasserted at pixel (2,1) -> no frame_done_o, no stale strobes; restarted frame yields its 4 windows correctly.
REQ-034 nreset_i=0 one cycle during row 2 -> all outputs 0 next cycle; state IDLE; next sof_i frame correct.
REQ-035 Back-to-back frames, second sof_i right after (3,3) -> 8 strobes, 2 frame_done_o pulses, no cross-frame window.
